watch_time_set_cnt: RTL



---
 rtl/watch_time_set_cnt_pkg.sv | 31 +++
 rtl/watch_time_set_cnt_if.sv | 25 ++
 rtl/watch_time_set_cnt_btn_debounce.sv | 58 +++++
 rtl/watch_time_set_cnt.sv | 129 ++++++++++++
 4 files changed

// File: rtl/watch_time_set_cnt_pkg.sv
// Shared encodings and limits for the watch time-keeping core.
// Mode and field-select encodings plus field wrap limits.
package watch_time_set_cnt_pkg;

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // Field selector rotates SEC -> MIN -> HOUR -> SEC.
    function automatic pos_t pos_step(input pos_t p);
        pos_t r;
        unique case (p)
            POS_SEC: r = POS_MIN;
            POS_MIN: r = POS_HOUR;
            default: r = POS_SEC;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/watch_time_set_cnt_if.sv
// Bundle between the watch core and its neighbours.
// Master drives tick/buttons and reads time; slave is the core.
interface watch_time_set_cnt_if;

    logic       i_tick_1hz;
    logic       i_sw_mode;
    logic       i_sw_pos;
    logic       i_sw_inc;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_mode;
    logic [1:0] o_pos;

    modport master (
        output i_tick_1hz, i_sw_mode, i_sw_pos, i_sw_inc,
        input  o_sec, o_min, o_hour, o_mode, o_pos
    );

    modport slave (
        input  i_tick_1hz, i_sw_mode, i_sw_pos, i_sw_inc,
        output o_sec, o_min, o_hour, o_mode, o_pos
    );

endinterface

// File: rtl/watch_time_set_cnt_btn_debounce.sv
// Synchronize and debounce one active-low button.
// Emits a single-cycle pulse when the debounced level falls.
module btn_debounce #(
    parameter int DEB_CYC = 1000000,
    parameter int DEB_W   = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_press
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic [DEB_W-1:0] cnt;
    logic             hit;

    assign hit = (sync2 != deb) && (cnt == CNT_LAST);

    // Two-flop synchronizer; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= i_sw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it stays stable long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= 1'b1;
            cnt <= '0;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (hit) begin
            deb <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pulse on the accepted 1->0 edge only; releases are silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_press <= 1'b0;
        end else begin
            o_press <= hit & ~sync2;
        end
    end

endmodule

// File: rtl/watch_time_set_cnt.sv
// Watch time-keeping core: CLOCK/SETUP mode FSM and h:m:s counters.
// Buttons are debounced here; the display stage consumes binary time.
module watch_time_set_cnt
    import watch_time_set_cnt_pkg::*;
#(
    parameter int DEB_CYC = 1000000,
    parameter int DEB_W   = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    watch_time_set_cnt_if.slave  bus
);

    mode_t      state;
    mode_t      state_n;
    pos_t       pos;
    pos_t       pos_n;
    logic [5:0] sec;
    logic [5:0] sec_n;
    logic [5:0] minute;
    logic [5:0] minute_n;
    logic [4:0] hour;
    logic [4:0] hour_n;
    logic       mode_p;
    logic       pos_p;
    logic       inc_p;

    btn_debounce #(.DEB_CYC(DEB_CYC), .DEB_W(DEB_W)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sw    (bus.i_sw_mode),
        .o_press (mode_p)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC), .DEB_W(DEB_W)) u_deb_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sw    (bus.i_sw_pos),
        .o_press (pos_p)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC), .DEB_W(DEB_W)) u_deb_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sw    (bus.i_sw_inc),
        .o_press (inc_p)
    );

    // State, field select and time registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MODE_CLOCK;
            pos    <= POS_SEC;
            sec    <= '0;
            minute <= '0;
            hour   <= '0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            sec    <= sec_n;
            minute <= minute_n;
            hour   <= hour_n;
        end
    end

    // Mode toggling and field selection; decisions use the current state.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        unique case (state)
            MODE_CLOCK: begin
                if (mode_p) begin
                    state_n = MODE_SETUP;
                    pos_n   = POS_SEC;
                end
            end
            MODE_SETUP: begin
                if (pos_p) pos_n = pos_step(pos);
                if (mode_p) state_n = MODE_CLOCK;
            end
            default: state_n = MODE_CLOCK;
        endcase
    end

    // Running clock with carries, or per-field set without carries.
    always_comb begin
        sec_n    = sec;
        minute_n = minute;
        hour_n   = hour;
        unique case (state)
            MODE_CLOCK: begin
                if (bus.i_tick_1hz) begin
                    if (sec == SEC_MAX) begin
                        sec_n = '0;
                        if (minute == MIN_MAX) begin
                            minute_n = '0;
                            hour_n   = (hour == HOUR_MAX) ? '0 : hour + 1'b1;
                        end else begin
                            minute_n = minute + 1'b1;
                        end
                    end else begin
                        sec_n = sec + 1'b1;
                    end
                end
            end
            MODE_SETUP: begin
                if (inc_p) begin
                    unique case (pos)
                        POS_SEC:
                            sec_n = (sec == SEC_MAX) ? '0 : sec + 1'b1;
                        POS_MIN:
                            minute_n = (minute == MIN_MAX) ? '0 : minute + 1'b1;
                        POS_HOUR:
                            hour_n = (hour == HOUR_MAX) ? '0 : hour + 1'b1;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign bus.o_sec  = sec;
    assign bus.o_min  = minute;
    assign bus.o_hour = hour;
    assign bus.o_mode = state;
    assign bus.o_pos  = pos;

endmodule
